// File: rtl/puf_eval_sequencer_if.sv
// Host/PUF-side bundle for puf_eval_sequencer.
// Optional PUF_SEQ_STABILITY_EN adds the unstable_mask result.
interface puf_eval_sequencer_if #(
    parameter int unsigned CHALLENGE_WIDTH  = 64,
    parameter int unsigned PDL_CONFIG_WIDTH = 64,
    parameter int unsigned RESPONSE_WIDTH   = 6,
    parameter int unsigned REPEAT_WIDTH     = 8
);
    logic                        start;
    logic [CHALLENGE_WIDTH-1:0]  challenge_in;
    logic [PDL_CONFIG_WIDTH-1:0] pdl_config_in;
    logic [REPEAT_WIDTH-1:0]     num_evals;
    logic                        busy;
    logic                        done;
    logic [CHALLENGE_WIDTH-1:0]  puf_challenge;
    logic [PDL_CONFIG_WIDTH-1:0] puf_pdl_config;
    logic                        puf_reset;
    logic                        puf_trigger;
    logic [RESPONSE_WIDTH-1:0]   puf_raw_response;
    logic                        puf_xor_response;
    logic [RESPONSE_WIDTH-1:0]   response_out;
    logic [REPEAT_WIDTH-1:0]     xor_ones_count;
`ifdef PUF_SEQ_STABILITY_EN
    logic [RESPONSE_WIDTH-1:0]   unstable_mask;

    modport master (
        output start, challenge_in, pdl_config_in, num_evals, puf_raw_response, puf_xor_response,
        input  busy, done, puf_challenge, puf_pdl_config, puf_reset, puf_trigger,
               response_out, xor_ones_count, unstable_mask
    );
    modport slave (
        input  start, challenge_in, pdl_config_in, num_evals, puf_raw_response, puf_xor_response,
        output busy, done, puf_challenge, puf_pdl_config, puf_reset, puf_trigger,
               response_out, xor_ones_count, unstable_mask
    );
`else
    modport master (
        output start, challenge_in, pdl_config_in, num_evals, puf_raw_response, puf_xor_response,
        input  busy, done, puf_challenge, puf_pdl_config, puf_reset, puf_trigger,
               response_out, xor_ones_count
    );
    modport slave (
        input  start, challenge_in, pdl_config_in, num_evals, puf_raw_response, puf_xor_response,
        output busy, done, puf_challenge, puf_pdl_config, puf_reset, puf_trigger,
               response_out, xor_ones_count
    );
`endif
endinterface

// File: rtl/puf_eval_sequencer.sv
// Repeats PUF reset/trigger/settle/sample N times and reports per-bit majority and XOR ones-count.
// Optional PUF_SEQ_STABILITY_EN adds unstable_mask (bits that were neither always 0 nor always 1).
module puf_eval_sequencer #(
    parameter int unsigned CHALLENGE_WIDTH  = 64,
    parameter int unsigned PDL_CONFIG_WIDTH = 64,
    parameter int unsigned RESPONSE_WIDTH   = 6,
    parameter int unsigned RESET_CYCLES     = 2,
    parameter int unsigned SETTLE_CYCLES    = 15,
    parameter int unsigned REPEAT_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    puf_eval_sequencer_if.slave  bus
);
    localparam int unsigned MAX_WAIT = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_PRESET, S_FIRE, S_SAMPLE, S_FINISH} state_t;

    state_t                      r_state, w_state_next;
    logic [CNT_W-1:0]            r_wait_cnt;
    logic [REPEAT_WIDTH-1:0]     r_num_evals, r_eval_cnt, r_xor_cnt, w_eval_cnt_inc;
    logic [REPEAT_WIDTH-1:0]     r_ones_cnt [RESPONSE_WIDTH];
    logic                        w_accept;
    logic                        w_busy, w_puf_reset, w_puf_trigger;
    logic                        r_busy, r_done, r_puf_reset, r_puf_trigger;
    logic [CHALLENGE_WIDTH-1:0]  r_challenge;
    logic [PDL_CONFIG_WIDTH-1:0] r_pdl_config;
    logic [RESPONSE_WIDTH-1:0]   r_response, w_majority;
    logic [REPEAT_WIDTH-1:0]     r_xor_ones;

    assign w_accept       = (r_state == S_IDLE) && bus.start;
    assign w_eval_cnt_inc = r_eval_cnt + REPEAT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_state_next = S_PRESET;
            S_PRESET: if (r_wait_cnt == RESET_LAST) w_state_next = S_FIRE;
            S_FIRE:   if (r_wait_cnt == SETTLE_LAST) w_state_next = S_SAMPLE;
            S_SAMPLE: w_state_next = (w_eval_cnt_inc == r_num_evals) ? S_FINISH : S_PRESET;
            S_FINISH: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from the next state so the registered copies line up with r_state.
    always_comb begin
        w_busy        = 1'b0;
        w_puf_reset   = 1'b1;
        w_puf_trigger = 1'b0;
        case (w_state_next)
            S_PRESET, S_FINISH: w_busy = 1'b1;
            S_FIRE, S_SAMPLE: begin
                w_busy        = 1'b1;
                w_puf_reset   = 1'b0;
                w_puf_trigger = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_puf_reset   <= 1'b1;
            r_puf_trigger <= 1'b0;
        end else begin
            r_busy        <= w_busy;
            r_done        <= (r_state == S_FINISH);
            r_puf_reset   <= w_puf_reset;
            r_puf_trigger <= w_puf_trigger;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (r_state != w_state_next)) r_wait_cnt <= '0;
        else                                    r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end

    // Majority uses REPEAT_WIDTH+1 bits so 2*count never wraps; a tie resolves to 0.
    always_comb begin
        w_majority = '0;
        for (int i = 0; i < int'(RESPONSE_WIDTH); i++)
            w_majority[i] = {r_ones_cnt[i], 1'b0} > {1'b0, r_num_evals};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_num_evals  <= '0;
            r_eval_cnt   <= '0;
            r_xor_cnt    <= '0;
            r_challenge  <= '0;
            r_pdl_config <= '0;
            r_response   <= '0;
            r_xor_ones   <= '0;
            for (int i = 0; i < int'(RESPONSE_WIDTH); i++) r_ones_cnt[i] <= '0;
        end else if (w_accept) begin
            r_num_evals  <= (bus.num_evals == '0) ? REPEAT_WIDTH'(1) : bus.num_evals;
            r_eval_cnt   <= '0;
            r_xor_cnt    <= '0;
            r_challenge  <= bus.challenge_in;
            r_pdl_config <= bus.pdl_config_in;
            for (int i = 0; i < int'(RESPONSE_WIDTH); i++) r_ones_cnt[i] <= '0;
        end else if (r_state == S_SAMPLE) begin
            r_eval_cnt <= w_eval_cnt_inc;
            r_xor_cnt  <= r_xor_cnt + REPEAT_WIDTH'(bus.puf_xor_response);
            for (int i = 0; i < int'(RESPONSE_WIDTH); i++)
                r_ones_cnt[i] <= r_ones_cnt[i] + REPEAT_WIDTH'(bus.puf_raw_response[i]);
        end else if (r_state == S_FINISH) begin
            r_response <= w_majority;
            r_xor_ones <= r_xor_cnt;
        end
    end

`ifdef PUF_SEQ_STABILITY_EN
    logic [RESPONSE_WIDTH-1:0] r_unstable, w_unstable;

    always_comb begin
        w_unstable = '0;
        for (int i = 0; i < int'(RESPONSE_WIDTH); i++)
            w_unstable[i] = (r_ones_cnt[i] != '0) && (r_ones_cnt[i] < r_num_evals);
    end

    always_ff @(posedge clk) begin
        if (reset)                      r_unstable <= '0;
        else if (r_state == S_FINISH)   r_unstable <= w_unstable;
    end

    assign bus.unstable_mask = r_unstable;
`endif

    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.puf_reset      = r_puf_reset;
    assign bus.puf_trigger    = r_puf_trigger;
    assign bus.puf_challenge  = r_challenge;
    assign bus.puf_pdl_config = r_pdl_config;
    assign bus.response_out   = r_response;
    assign bus.xor_ones_count = r_xor_ones;
endmodule

// File: tb/tb_puf_eval_sequencer.sv
// Directed bench for puf_eval_sequencer with a table-driven PUF response model.
module tb_puf_eval_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    puf_eval_sequencer_if #(.CHALLENGE_WIDTH(64), .PDL_CONFIG_WIDTH(64),
                            .RESPONSE_WIDTH(6), .REPEAT_WIDTH(8)) bus ();

    puf_eval_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // PUF model: response index advances each time the trigger falls.
    logic [5:0] raw_pat [8];
    logic       xor_pat [8];
    int         trig_falls = 0;
    int         pat_base   = 0;
    logic       trig_d     = 1'b0;
    logic [2:0] pat_idx;

    always @(posedge clk) begin
        trig_d <= bus.puf_trigger;
        if (trig_d && !bus.puf_trigger) trig_falls <= trig_falls + 1;
    end

    assign pat_idx              = 3'(trig_falls - pat_base);
    assign bus.puf_raw_response = raw_pat[pat_idx];
    assign bus.puf_xor_response = xor_pat[pat_idx];

    task automatic run_op(input logic [7:0] n, input logic [63:0] ch, input logic [63:0] cfg,
                          input int ign_at, output int lat, output int trig_hi,
                          output int dones, output logic busy1);
        lat = -1; trig_hi = 0; dones = 0;
        pat_base          = trig_falls;
        bus.num_evals     = n;
        bus.challenge_in  = ch;
        bus.pdl_config_in = cfg;
        bus.start         = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy1     = bus.busy;
        for (int cyc = 1; cyc <= 1000; cyc++) begin
            @(posedge clk); #1;
            bus.start = (cyc == ign_at);
            if (cyc == ign_at) bus.challenge_in = ~ch;
            if (bus.puf_trigger) trig_hi++;
            if (bus.done) begin
                dones++;
                if (lat < 0) lat = cyc;
            end
            if (lat >= 0 && cyc >= lat + 3) break;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (bus.puf_reset !== 1'b1) begin n_bad++; $display("FAIL reset_puf_reset got %b exp 1", bus.puf_reset); end
        n_cmp++; if (bus.puf_trigger !== 1'b0) begin n_bad++; $display("FAIL reset_trigger got %b exp 0", bus.puf_trigger); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b exp 0", bus.done); end
        n_cmp++; if (bus.response_out !== 6'd0) begin n_bad++; $display("FAIL reset_response got %b exp 000000", bus.response_out); end
        n_cmp++; if (bus.xor_ones_count !== 8'd0) begin n_bad++; $display("FAIL reset_xor_count got %0d exp 0", bus.xor_ones_count); end
        n_cmp++; if (bus.puf_challenge !== 64'd0) begin n_bad++; $display("FAIL reset_challenge got %h exp 0", bus.puf_challenge); end
`ifdef PUF_SEQ_STABILITY_EN
        n_cmp++; if (bus.unstable_mask !== 6'd0) begin n_bad++; $display("FAIL reset_unstable got %b exp 000000", bus.unstable_mask); end
`endif
    endtask

    task automatic test_single_eval();
        int lat, th, dn; logic b1;
        raw_pat[0] = 6'b101101; xor_pat[0] = 1'b0;
        run_op(8'd1, 64'hDEAD_BEEF_0123_4567, 64'h0F0F_1234_5678_9ABC, 0, lat, th, dn, b1);
        n_cmp++; if (b1 !== 1'b1) begin n_bad++; $display("FAIL single_busy_after_start got %b exp 1", b1); end
        n_cmp++; if (lat !== 19) begin n_bad++; $display("FAIL single_latency got %0d exp 19", lat); end
        n_cmp++; if (th !== 16) begin n_bad++; $display("FAIL single_trigger_cycles got %0d exp 16", th); end
        n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL single_done_count got %0d exp 1", dn); end
        n_cmp++; if (bus.response_out !== 6'b101101) begin n_bad++; $display("FAIL single_response got %b exp 101101", bus.response_out); end
        n_cmp++; if (bus.xor_ones_count !== 8'd0) begin n_bad++; $display("FAIL single_xor_count got %0d exp 0", bus.xor_ones_count); end
        n_cmp++; if (bus.puf_challenge !== 64'hDEAD_BEEF_0123_4567) begin n_bad++; $display("FAIL single_challenge got %h exp deadbeef01234567", bus.puf_challenge); end
        n_cmp++; if (bus.puf_pdl_config !== 64'h0F0F_1234_5678_9ABC) begin n_bad++; $display("FAIL single_pdl got %h exp 0f0f123456789abc", bus.puf_pdl_config); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_after_done got %b exp 0", bus.busy); end
        n_cmp++; if (bus.puf_reset !== 1'b1) begin n_bad++; $display("FAIL single_puf_reset_idle got %b exp 1", bus.puf_reset); end
    endtask

    task automatic test_majority3();
        int lat, th, dn; logic b1;
        raw_pat[0] = 6'b000011; xor_pat[0] = 1'b1;
        raw_pat[1] = 6'b000001; xor_pat[1] = 1'b1;
        raw_pat[2] = 6'b000010; xor_pat[2] = 1'b0;
        run_op(8'd3, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 0, lat, th, dn, b1);
        n_cmp++; if (lat !== 55) begin n_bad++; $display("FAIL maj3_latency got %0d exp 55", lat); end
        n_cmp++; if (th !== 48) begin n_bad++; $display("FAIL maj3_trigger_cycles got %0d exp 48", th); end
        n_cmp++; if (bus.response_out !== 6'b000011) begin n_bad++; $display("FAIL maj3_response got %b exp 000011", bus.response_out); end
        n_cmp++; if (bus.xor_ones_count !== 8'd2) begin n_bad++; $display("FAIL maj3_xor_count got %0d exp 2", bus.xor_ones_count); end
`ifdef PUF_SEQ_STABILITY_EN
        n_cmp++; if (bus.unstable_mask !== 6'b000011) begin n_bad++; $display("FAIL maj3_unstable got %b exp 000011", bus.unstable_mask); end
`endif
    endtask

    task automatic test_zero_evals();
        int lat, th, dn; logic b1;
        raw_pat[0] = 6'b010110; xor_pat[0] = 1'b1;
        run_op(8'd0, 64'hA5A5_A5A5_5A5A_5A5A, 64'h0000_0000_FFFF_FFFF, 0, lat, th, dn, b1);
        n_cmp++; if (lat !== 19) begin n_bad++; $display("FAIL zero_latency got %0d exp 19", lat); end
        n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL zero_done_count got %0d exp 1", dn); end
        n_cmp++; if (bus.response_out !== 6'b010110) begin n_bad++; $display("FAIL zero_response got %b exp 010110", bus.response_out); end
        n_cmp++; if (bus.xor_ones_count !== 8'd1) begin n_bad++; $display("FAIL zero_xor_count got %0d exp 1", bus.xor_ones_count); end
    endtask

    task automatic test_tie_ignored_start();
        int lat, th, dn; logic b1;
        raw_pat[0] = 6'b000001; xor_pat[0] = 1'b0;
        raw_pat[1] = 6'b100001; xor_pat[1] = 1'b1;
        raw_pat[2] = 6'b100000; xor_pat[2] = 1'b1;
        raw_pat[3] = 6'b100000; xor_pat[3] = 1'b1;
        run_op(8'd4, 64'hCAFE_F00D_1357_9BDF, 64'h2468_ACE0_1122_3344, 10, lat, th, dn, b1);
        n_cmp++; if (lat !== 73) begin n_bad++; $display("FAIL tie_latency got %0d exp 73", lat); end
        n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL tie_done_count got %0d exp 1", dn); end
        n_cmp++; if (bus.response_out !== 6'b100000) begin n_bad++; $display("FAIL tie_response got %b exp 100000", bus.response_out); end
        n_cmp++; if (bus.xor_ones_count !== 8'd3) begin n_bad++; $display("FAIL tie_xor_count got %0d exp 3", bus.xor_ones_count); end
        n_cmp++; if (bus.puf_challenge !== 64'hCAFE_F00D_1357_9BDF) begin n_bad++; $display("FAIL tie_challenge_held got %h exp cafef00d13579bdf", bus.puf_challenge); end
`ifdef PUF_SEQ_STABILITY_EN
        n_cmp++; if (bus.unstable_mask !== 6'b100001) begin n_bad++; $display("FAIL tie_unstable got %b exp 100001", bus.unstable_mask); end
`endif
    endtask

    task automatic test_abort();
        int lat, th, dn, dones; logic b1;
        dones = 0;
        raw_pat[0] = 6'b111111; xor_pat[0] = 1'b1;
        raw_pat[1] = 6'b111111; xor_pat[1] = 1'b1;
        pat_base          = trig_falls;
        bus.num_evals     = 8'd2;
        bus.challenge_in  = 64'h0BAD_0BAD_0BAD_0BAD;
        bus.pdl_config_in = 64'h7777_7777_7777_7777;
        bus.start         = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b exp 0", bus.busy); end
        n_cmp++; if (bus.puf_reset !== 1'b1) begin n_bad++; $display("FAIL abort_puf_reset got %b exp 1", bus.puf_reset); end
        n_cmp++; if (bus.puf_trigger !== 1'b0) begin n_bad++; $display("FAIL abort_trigger got %b exp 0", bus.puf_trigger); end
        n_cmp++; if (bus.puf_challenge !== 64'd0) begin n_bad++; $display("FAIL abort_challenge got %h exp 0", bus.puf_challenge); end
        n_cmp++; if (bus.response_out !== 6'd0) begin n_bad++; $display("FAIL abort_response got %b exp 000000", bus.response_out); end
        n_cmp++; if (bus.xor_ones_count !== 8'd0) begin n_bad++; $display("FAIL abort_xor_count got %0d exp 0", bus.xor_ones_count); end
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL abort_no_done got %0d exp 0", dones); end
        raw_pat[0] = 6'b110000; xor_pat[0] = 1'b1;
        raw_pat[1] = 6'b100001; xor_pat[1] = 1'b0;
        run_op(8'd2, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 0, lat, th, dn, b1);
        n_cmp++; if (lat !== 37) begin n_bad++; $display("FAIL restart_latency got %0d exp 37", lat); end
        n_cmp++; if (bus.response_out !== 6'b100000) begin n_bad++; $display("FAIL restart_response got %b exp 100000", bus.response_out); end
        n_cmp++; if (bus.xor_ones_count !== 8'd1) begin n_bad++; $display("FAIL restart_xor_count got %0d exp 1", bus.xor_ones_count); end
    endtask

    initial begin
        reset             = 1'b1;
        bus.start         = 1'b0;
        bus.num_evals     = '0;
        bus.challenge_in  = '0;
        bus.pdl_config_in = '0;
        for (int i = 0; i < 8; i++) begin raw_pat[i] = '0; xor_pat[i] = 1'b0; end
        test_reset();
        test_single_eval();
        test_majority3();
        test_zero_evals();
        test_tie_ignored_start();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/puf_eval_sequencer.md
Name: puf_eval_sequencer

Overview:
- Sequences repeated evaluations of the PUF datapath (input network, interconnect network, output network) for one challenge/PDL-config pair.
- Per evaluation: drives PUF reset, raises the PUF trigger, waits a settle window, then samples the raw and XOR responses.
- Accumulates the samples over N evaluations and returns a per-bit majority response plus the XOR-response ones-count.
- Sits between the host-side command handler and the PUF datapath, replacing ad-hoc trigger/wait logic.

Parameters:
- CHALLENGE_WIDTH, 64, challenge bits
- PDL_CONFIG_WIDTH, 64, PDL configuration bits
- RESPONSE_WIDTH, 6, raw response bits
- RESET_CYCLES, 2, cycles puf_reset is held per evaluation (>=1)
- SETTLE_CYCLES, 15, cycles trigger is high before sampling (>=1)
- REPEAT_WIDTH, 8, width of evaluation count and ones-counters

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request pulse; accepted only when busy=0
- challenge_in  in  CHALLENGE_WIDTH  challenge, latched on accepted start
- pdl_config_in  in  PDL_CONFIG_WIDTH  PDL config, latched on accepted start
- num_evals  in  REPEAT_WIDTH  evaluation count, latched on accepted start; 0 is treated as 1
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse; result outputs valid from this cycle
- puf_challenge  out  CHALLENGE_WIDTH  latched challenge driven to the PUF
- puf_pdl_config  out  PDL_CONFIG_WIDTH  latched config driven to the PUF
- puf_reset  out  1  PUF reset
- puf_trigger  out  1  PUF trigger
- puf_raw_response  in  RESPONSE_WIDTH  raw response from the PUF
- puf_xor_response  in  1  XOR response from the PUF
- response_out  out  RESPONSE_WIDTH  per-bit majority result
- xor_ones_count  out  REPEAT_WIDTH  number of samples with puf_xor_response=1

Behaviour:
- Reset values: busy=0, done=0, puf_reset=1, puf_trigger=0, puf_challenge=0, puf_pdl_config=0, response_out=0, xor_ones_count=0. All internal counters cleared; state goes to IDLE.
- States: IDLE, PRESET, FIRE, SAMPLE, FINISH.
- IDLE:
  - puf_reset=1, puf_trigger=0.
  - start=1 latches inputs, clears per-bit ones-counters, eval counter and xor counter, then moves to PRESET.
- PRESET: puf_reset=1, trigger=0 for RESET_CYCLES cycles, then FIRE.
- FIRE: puf_reset=0, trigger=1 for SETTLE_CYCLES cycles, then SAMPLE.
- SAMPLE (1 cycle):
  - puf_reset=0, trigger=1.
  - Each ones-counter[i] increments if puf_raw_response[i]=1; the xor counter increments if puf_xor_response=1.
  - The eval counter increments.
  - If the eval counter now equals N, go to FINISH; else go to PRESET.
- FINISH (1 cycle):
  - done=1, busy=0.
  - response_out[i]=1 iff 2*count[i] > N (a tie gives 0).
  - xor_ones_count is updated.
  - puf_reset=1; return to IDLE.
  - response_out and xor_ones_count then hold until the next FINISH or reset.
- Latency: done is asserted exactly N*(RESET_CYCLES+SETTLE_CYCLES+1)+1 cycles after the edge that accepted start.
- start while busy or in FINISH: ignored, with no queuing.
- start in the same cycle as reset: reset wins.
- Counters are REPEAT_WIDTH wide and cannot overflow because count <= N <= 2^REPEAT_WIDTH-1. The 2*count comparison uses REPEAT_WIDTH+1 bits.
- Reset mid-operation: abort immediately to reset values; no done pulse is produced.
- puf_challenge and puf_pdl_config stay stable for the whole operation and after it, until the next accepted start.

Optional Feature:
- Macro: PUF_SEQ_STABILITY_EN.
- Defined:
  - Adds output unstable_mask [RESPONSE_WIDTH-1:0], reset value 0.
  - Updated in FINISH: bit i = 1 iff 0 < count[i] < N.
  - Held until the next FINISH.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then idle 5 cycles -> puf_reset=1, trigger=0, busy=0, done=0, response_out=0.
- Defaults, num_evals=1, PUF model returns raw=6'b101101, xor=0 -> trigger high 16 cycles, done exactly 19 cycles after start, response_out=6'b101101, xor_ones_count=0.
- num_evals=3, model returns raw=6'b000011, 6'b000001, 6'b000010 with xor=1,1,0 -> done at 55 cycles, response_out=6'b000011, xor_ones_count=2. With PUF_SEQ_STABILITY_EN: unstable_mask=6'b000011.
- num_evals=0 -> behaves exactly as num_evals=1 (done at 19 cycles).
- num_evals=4, model bit0 pattern 1,1,0,0 -> tie, so response_out[0]=0. A second start pulse at cycle 10 is ignored: exactly one done, and puf_challenge stays unchanged.
- Assert reset at cycle 8 of a num_evals=2 run -> no done pulse, outputs at reset values. A fresh start afterwards completes normally in 37 cycles.
